// File: rtl/hyperbus_pkg.sv
// Shared types for the HyperBus config path: reg bus structs and cfg loader enums.
// The READ state exists only when HYPERBUS_CFG_LOADER_READBACK_EN is defined.
package hyperbus_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } hyperbus_reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } hyperbus_reg_rsp_t;

  typedef enum logic [1:0] {
    ErrNone     = 2'd0,
    ErrSlave    = 2'd1,
    ErrTimeout  = 2'd2,
    ErrReadback = 2'd3
  } cfg_loader_err_e;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
`ifdef HYPERBUS_CFG_LOADER_READBACK_EN
    StRead,
`endif
    StDone,
    StError
  } cfg_loader_state_e;

endpackage

// File: rtl/hyperbus_cfg_loader.sv
// Boot-time sequencer writing a table of (addr, data) pairs to the HyperBus config regs.
// Define HYPERBUS_CFG_LOADER_READBACK_EN to verify every write with a read of the same address.
module hyperbus_cfg_loader
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumEntries    = 4,
  parameter int unsigned RegAddrWidth  = 32,
  parameter int unsigned RegDataWidth  = 32,
  parameter type         reg_req_t     = hyperbus_reg_req_t,
  parameter type         reg_rsp_t     = hyperbus_reg_rsp_t,
  parameter logic [NumEntries-1:0][RegAddrWidth-1:0] EntryAddr = '0,
  parameter logic [NumEntries-1:0][RegDataWidth-1:0] EntryData = '0,
  parameter bit          AutoStart     = 1'b1,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  reg_req_t ext_req_i,
  output reg_rsp_t ext_rsp_o,
  output reg_req_t cfg_req_o,
  input  reg_rsp_t cfg_rsp_i,
  input  logic     start_i,
  output logic     busy_o,
  output logic     done_o,
  output logic     error_o,
  output logic [1:0] err_code_o,
  output logic [$clog2((NumEntries > 2) ? NumEntries : 2)-1:0] err_idx_o
);

  localparam int unsigned IdxW   = $clog2((NumEntries > 2) ? NumEntries : 2);
  localparam int unsigned TimerW = $clog2(TimeoutCycles);
  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(NumEntries - 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TimeoutCycles - 1);

  cfg_loader_state_e state_q;
  cfg_loader_err_e   errCode_q;
  logic [IdxW-1:0]   idx_q;
  logic [IdxW-1:0]   errIdx_q;
  logic [TimerW-1:0] timer_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic              first_q;
  reg_req_t          loaderReq;

  // first_q marks the single cycle after reset release in which AutoStart may fire
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      errCode_q <= ErrNone;
      idx_q     <= '0;
      errIdx_q  <= '0;
      timer_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      first_q   <= 1'b1;
    end else begin
      first_q <= 1'b0;
      if (!busy_q) begin
        if (start_i || (first_q && AutoStart)) begin
          state_q   <= StWrite;
          busy_q    <= 1'b1;
          idx_q     <= '0;
          timer_q   <= '0;
          done_q    <= 1'b0;
          error_q   <= 1'b0;
          errCode_q <= ErrNone;
          errIdx_q  <= '0;
        end
      end else if (cfg_rsp_i.ready) begin
        timer_q <= '0;
        if (cfg_rsp_i.error) begin
          state_q   <= StError;
          busy_q    <= 1'b0;
          error_q   <= 1'b1;
          errCode_q <= ErrSlave;
          errIdx_q  <= idx_q;
`ifdef HYPERBUS_CFG_LOADER_READBACK_EN
        end else if (state_q == StWrite) begin
          state_q <= StRead;
        end else if (cfg_rsp_i.rdata != EntryData[idx_q]) begin
          state_q   <= StError;
          busy_q    <= 1'b0;
          error_q   <= 1'b1;
          errCode_q <= ErrReadback;
          errIdx_q  <= idx_q;
`endif
        end else if (idx_q == LastIdx) begin
          state_q <= StDone;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q <= StWrite;
          idx_q   <= idx_q + 1'b1;
        end
      end else if (timer_q == TimerMax) begin
        state_q   <= StError;
        busy_q    <= 1'b0;
        error_q   <= 1'b1;
        errCode_q <= ErrTimeout;
        errIdx_q  <= idx_q;
      end else begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  // Ownership follows the registered busy flag, so the mux only flips at a clock edge
  always_comb begin
    loaderReq       = '0;
    loaderReq.valid = 1'b1;
    loaderReq.write = (state_q == StWrite);
    loaderReq.addr  = EntryAddr[idx_q];
    loaderReq.wdata = (state_q == StWrite) ? EntryData[idx_q] : '0;
    loaderReq.wstrb = (state_q == StWrite) ? '1 : '0;
    if (busy_q) begin
      cfg_req_o = loaderReq;
      ext_rsp_o = '0;
    end else begin
      cfg_req_o = ext_req_i;
      ext_rsp_o = cfg_rsp_i;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign error_o    = error_q;
  assign err_code_o = errCode_q;
  assign err_idx_o  = errIdx_q;

endmodule

// File: tb/tb_hyperbus_cfg_loader.sv
// Directed self-checking bench for hyperbus_cfg_loader with a small memory-backed reg slave.
// Readback expectations follow HYPERBUS_CFG_LOADER_READBACK_EN.
module tb_hyperbus_cfg_loader;
  import hyperbus_pkg::*;

`ifdef HYPERBUS_CFG_LOADER_READBACK_EN
  localparam int HS = 2;
`else
  localparam int HS = 1;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        write;
    int          cyc;
  } hs_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, done, error;
  logic [1:0] errCode;
  logic [1:0] errIdx;
  hyperbus_reg_req_t extReq, cfgReq;
  hyperbus_reg_rsp_t extRsp, cfgRsp;

  logic [31:0] stallAddr = 32'hffff_ffff;
  int          stallLeft = 0;
  logic        slvErrEn = 1'b0;
  logic [31:0] errAddr = 32'h0;
  logic        corrupt = 1'b0;
  logic [31:0] mem [16];
  int          cyc = 0;
  hs_t         hsLog [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hyperbus_cfg_loader #(
    .NumEntries   (3),
    .RegAddrWidth (32),
    .RegDataWidth (32),
    .reg_req_t    (hyperbus_reg_req_t),
    .reg_rsp_t    (hyperbus_reg_rsp_t),
    .EntryAddr    ({32'h8, 32'h4, 32'h0}),
    .EntryData    ({32'h20, 32'h1, 32'h5}),
    .AutoStart    (1'b1),
    .TimeoutCycles(8)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .ext_req_i (extReq),
    .ext_rsp_o (extRsp),
    .cfg_req_o (cfgReq),
    .cfg_rsp_i (cfgRsp),
    .start_i   (start),
    .busy_o    (busy),
    .done_o    (done),
    .error_o   (error),
    .err_code_o(errCode),
    .err_idx_o (errIdx)
  );

  // Slave model: stalls, errors or corrupts reads for selected addresses
  always_comb begin
    cfgRsp.ready = !(cfgReq.valid && (cfgReq.addr == stallAddr) && (stallLeft > 0));
    cfgRsp.error = slvErrEn && cfgReq.valid && (cfgReq.addr == errAddr);
    cfgRsp.rdata = (corrupt && cfgReq.addr == 32'h8) ? 32'h21 : mem[cfgReq.addr[5:2]];
  end

  // Handshake logger and memory update, non-blocking so the DUT sees pre-edge slave state
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cfgReq.valid) begin
      if (cfgRsp.ready) begin
        hsLog.push_back('{cfgReq.addr, cfgReq.wdata, cfgReq.write, cyc});
        if (cfgReq.write && !cfgRsp.error) mem[cfgReq.addr[5:2]] <= cfgReq.wdata;
      end else begin
        stallLeft <= stallLeft - 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitEnd(input int limit, output int n);
    n = 0;
    while (!(done || error) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!(done || error)) checkOutput("wait_bound", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int k;
    int w0;
    int w1;
    logic [31:0] expAddr [3];
    logic [31:0] expData [3];
    expAddr = '{32'h0, 32'h4, 32'h8};
    expData = '{32'h5, 32'h1, 32'h20};
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rst = 1'b1;
    start = 1'b0;
    extReq = '0;

    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_error", error, 1'b0);
    checkOutput("rst_code", errCode, 2'd0);
    checkOutput("rst_idx", errIdx, 2'd0);

    $display("[TB] autostart load");
    hsLog.delete();
    rst = 1'b0;
    waitEnd(40, n);
    checkOutput("auto_cycles", n, 1 + 3 * HS);
    checkOutput("auto_done", done, 1'b1);
    checkOutput("auto_busy", busy, 1'b0);
    checkOutput("auto_hs_count", hsLog.size(), 3 * HS);
    k = 0;
    for (int i = 0; i < hsLog.size(); i++) begin
      if (i > 0) checkOutput("auto_back_to_back", hsLog[i].cyc - hsLog[i-1].cyc, 1);
      if (hsLog[i].write && k < 3) begin
        checkOutput("auto_addr", hsLog[i].addr, expAddr[k]);
        checkOutput("auto_data", hsLog[i].data, expData[k]);
        k++;
      end
    end
    checkOutput("auto_write_count", k, 3);

    $display("[TB] stall on entry 1");
    stallAddr = 32'h4;
    stallLeft = 5;
    hsLog.delete();
    applyStimulus();
    checkOutput("stall_busy", busy, 1'b1);
    checkOutput("stall_done_cleared", done, 1'b0);
    n = 0;
    while (!(done || error) && n < 60) begin
      if (!cfgRsp.ready) begin
        checkOutput("stall_hold_addr", cfgReq.addr, 32'h4);
        checkOutput("stall_hold_data", cfgReq.wdata, 32'h1);
      end
      @(negedge clk);
      n++;
    end
    checkOutput("stall_done", done, 1'b1);
    checkOutput("stall_error", error, 1'b0);
    checkOutput("stall_hs_count", hsLog.size(), 3 * HS);
    w0 = -1;
    w1 = -1;
    for (int i = 0; i < hsLog.size(); i++) begin
      if (hsLog[i].write && hsLog[i].addr == 32'h0) w0 = hsLog[i].cyc;
      if (hsLog[i].write && hsLog[i].addr == 32'h4) w1 = hsLog[i].cyc;
    end
    checkOutput("stall_gap", w1 - w0, HS + 5);
    stallLeft = 0;

    $display("[TB] timeout on entry 2");
    stallAddr = 32'h8;
    stallLeft = 100;
    applyStimulus();
    waitEnd(60, n);
    checkOutput("to_error", error, 1'b1);
    checkOutput("to_code", errCode, 2'd2);
    checkOutput("to_idx", errIdx, 2'd2);
    checkOutput("to_busy", busy, 1'b0);
    checkOutput("to_done", done, 1'b0);
    stallLeft = 0;
    stallAddr = 32'hffff_ffff;

    $display("[TB] slave error on entry 0, then rerun");
    slvErrEn = 1'b1;
    errAddr = 32'h0;
    applyStimulus();
    waitEnd(40, n);
    checkOutput("slverr_error", error, 1'b1);
    checkOutput("slverr_code", errCode, 2'd1);
    checkOutput("slverr_idx", errIdx, 2'd0);
    slvErrEn = 1'b0;
    applyStimulus();
    checkOutput("rerun_error_cleared", error, 1'b0);
    waitEnd(40, n);
    checkOutput("rerun_done", done, 1'b1);
    checkOutput("rerun_error", error, 1'b0);
    checkOutput("rerun_code", errCode, 2'd0);

`ifdef HYPERBUS_CFG_LOADER_READBACK_EN
    $display("[TB] readback mismatch on entry 2");
    corrupt = 1'b1;
    applyStimulus();
    waitEnd(40, n);
    checkOutput("rb_error", error, 1'b1);
    checkOutput("rb_code", errCode, 2'd3);
    checkOutput("rb_idx", errIdx, 2'd2);
    corrupt = 1'b0;
`endif

    $display("[TB] external traffic around a load");
    @(negedge clk);
    start = 1'b1;
    extReq.addr  = 32'h14;
    extReq.write = 1'b1;
    extReq.wdata = 32'h7;
    extReq.wstrb = 4'hf;
    extReq.valid = 1'b1;
    #1;
    checkOutput("ext_start_ready", extRsp.ready, 1'b1);
    checkOutput("ext_start_addr", cfgReq.addr, 32'h14);
    @(negedge clk);
    start = 1'b0;
    extReq.addr  = 32'h10;
    extReq.wdata = 32'h3;
    checkOutput("ext_start_busy", busy, 1'b1);
    checkOutput("ext_start_mem", mem[5], 32'h7);
    n = 0;
    while (busy && n < 40) begin
      #1;
      checkOutput("ext_stall_ready", extRsp.ready, 1'b0);
      checkOutput("ext_stall_rdata", extRsp.rdata, 32'h0);
      checkOutput("ext_not_forwarded", mem[4], 32'h0);
      @(negedge clk);
      n++;
    end
    checkOutput("ext_busy_fell", busy, 1'b0);
    #1;
    checkOutput("ext_pass_addr", cfgReq.addr, 32'h10);
    checkOutput("ext_pass_write", cfgReq.write, 1'b1);
    checkOutput("ext_pass_ready", extRsp.ready, 1'b1);
    checkOutput("ext_load_done", done, 1'b1);
    @(negedge clk);
    extReq.addr  = 32'h4;
    extReq.write = 1'b0;
    extReq.wdata = 32'h0;
    extReq.wstrb = 4'h0;
    #1;
    checkOutput("ext_write_landed", mem[4], 32'h3);
    checkOutput("ext_read_rdata", extRsp.rdata, 32'h1);
    checkOutput("ext_read_ready", extRsp.ready, 1'b1);
    @(negedge clk);
    extReq = '0;

    $display("[TB] reset mid-load");
    applyStimulus();
    @(negedge clk);
    checkOutput("midrst_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_done", done, 1'b0);
    hsLog.delete();
    rst = 1'b0;
    waitEnd(40, n);
    checkOutput("midrst_rerun_done", done, 1'b1);
    checkOutput("midrst_hs_count", hsLog.size(), 3 * HS);
    if (hsLog.size() > 0) begin
      checkOutput("midrst_first_addr", hsLog[0].addr, 32'h0);
      checkOutput("midrst_first_write", hsLog[0].write, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
